// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight,
// and hands {pc, instruction} to decode through an output register plus skid entry.
`ifndef XLEN
`define XLEN 32
`endif

module instr_fetch #(
   parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst_b,
   output logic             imem_req,
   output logic [`XLEN-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [`XLEN-1:0] imem_rdata,
   input  logic             ex_redirect,
   input  logic [`XLEN-1:0] ex_redirect_pc,
   input  logic             id_pipe_ready,
   output logic             id_pipe_valid,
   output logic [`XLEN-1:0] id_pc,
   output logic [`XLEN-1:0] id_instruction
);

   localparam int XW = `XLEN;

   logic [XW-1:0] fetch_pc;
   logic [XW-1:0] req_pc;
   logic          outstanding;
   logic          drop;

   logic          out_valid;
   logic [XW-1:0] out_pc;
   logic [XW-1:0] out_instr;

   logic          skid_valid;
   logic [XW-1:0] skid_pc;
   logic [XW-1:0] skid_instr;

   logic          resp;
   logic          out_free;
   logic          out_load_skid;
   logic          out_load_resp;
   logic          skid_load;
   logic          grant;
   logic          out_valid_next;
   logic          skid_valid_next;
   logic          outstanding_next;
   logic          drop_next;
   logic [XW-1:0] fetch_pc_next;
   logic          unused_bits;

   assign unused_bits = ^ex_redirect_pc[1:0];

   // Buffer steering: skid is always older than a response arriving this cycle.
   always_comb begin
      resp          = imem_rvalid & outstanding & ~drop;
      out_free      = ~out_valid | id_pipe_ready;
      out_load_skid = ~ex_redirect & out_free & skid_valid;
      out_load_resp = ~ex_redirect & out_free & ~skid_valid & resp;
      skid_load     = ~ex_redirect & resp & ~out_load_resp;

      out_valid_next  = ~ex_redirect & (out_load_skid | out_load_resp | (out_valid & ~out_free));
      skid_valid_next = skid_load | (skid_valid & ~out_load_skid & ~ex_redirect);
   end

   // A new request needs the slot free (or freeing now) and a skid that stays empty,
   // which is what bounds the buffer to two entries.
   always_comb begin
      imem_req  = rst_b & ~ex_redirect & (~outstanding | imem_rvalid) & ~skid_valid_next;
      imem_addr = fetch_pc;
      grant     = imem_req & imem_gnt;

      outstanding_next = grant | (outstanding & ~imem_rvalid);

      if (ex_redirect) begin
         drop_next     = outstanding & ~imem_rvalid;
         fetch_pc_next = {ex_redirect_pc[XW-1:2], 2'b00};
      end else begin
         drop_next     = drop & ~imem_rvalid;
         fetch_pc_next = grant ? fetch_pc + XW'(4) : fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         fetch_pc    <= {RESET_PC[XW-1:2], 2'b00};
         outstanding <= 1'b0;
         drop        <= 1'b0;
         out_valid   <= 1'b0;
         skid_valid  <= 1'b0;
      end else begin
         fetch_pc    <= fetch_pc_next;
         outstanding <= outstanding_next;
         drop        <= drop_next;
         out_valid   <= out_valid_next;
         skid_valid  <= skid_valid_next;
      end
   end

   // Payload registers carry no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (grant) begin
         req_pc <= fetch_pc;
      end
      if (out_load_skid) begin
         out_pc    <= skid_pc;
         out_instr <= skid_instr;
      end else if (out_load_resp) begin
         out_pc    <= req_pc;
         out_instr <= imem_rdata;
      end
      if (skid_load) begin
         skid_pc    <= req_pc;
         skid_instr <= imem_rdata;
      end
   end

   assign id_pipe_valid  = out_valid;
   assign id_pc          = out_pc;
   assign id_instruction = out_instr;

`ifndef SYNTHESIS
   skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_b)
      !(skid_valid && resp));
`endif

endmodule
